// File: rtl/call_ret_ctrl.sv
// Return-address stack controller: CALL/RET to push/pop strobes and next PC.
// Ports: clk, rst(n); call, ret, pc, target, stk_rdata in; push, pop,
// stk_wdata, next_pc, stall, depth, overflow, underflow, fault out.
module call_ret_ctrl #(
  parameter int AW    = 12,
  parameter int DEPTH = 8,
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stk_rdata,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] stk_wdata,
  output logic [AW-1:0] next_pc,
  output logic          stall,
  output logic [DW-1:0] depth,
  output logic          overflow,
  output logic          underflow,
  output logic          fault
);

  typedef enum logic [1:0] {
    IDLE,
    RET_WAIT,
    FAULT
  } state_t;

  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_t        state, state_d;
  logic [DW-1:0] depth_d;
  logic          ovf_d, unf_d;
  logic [AW-1:0] pc_inc;

  assign pc_inc    = pc + AW'(1);
  assign stk_wdata = pc_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_d;
      depth     <= depth_d;
      overflow  <= ovf_d;
      underflow <= unf_d;
    end
  end

  // Outputs are gated by rst so reset looks idle even with call/ret high.
  always_comb begin
    state_d = state;
    depth_d = depth;
    ovf_d   = overflow;
    unf_d   = underflow;
    push    = 1'b0;
    pop     = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    next_pc = pc_inc;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (call) begin
            if (depth != FULL) begin
              push    = 1'b1;
              next_pc = target;
              depth_d = depth + DW'(1);
            end else begin
              stall   = 1'b1;
              next_pc = pc;
              ovf_d   = 1'b1;
              state_d = FAULT;
            end
          end else if (ret) begin
            stall   = 1'b1;
            next_pc = pc;
            if (depth != '0) begin
              pop     = 1'b1;
              depth_d = depth - DW'(1);
              state_d = RET_WAIT;
            end else begin
              unf_d   = 1'b1;
              state_d = FAULT;
            end
          end
        end
        // Popped entry is visible on the read port one cycle later.
        RET_WAIT: begin
          next_pc = stk_rdata;
          state_d = IDLE;
        end
        FAULT: begin
          stall   = 1'b1;
          fault   = 1'b1;
          next_pc = pc;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Self-checking bench for call_ret_ctrl.
// Expected outputs queued on drive, popped and compared at negedge.
module tb_call_ret_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        call, ret;
  logic [11:0] pc, target, stk_rdata;
  logic        push, pop, stall, overflow, underflow, fault;
  logic [11:0] stk_wdata, next_pc;
  logic [3:0]  depth;

  call_ret_ctrl #(.AW(12), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .pc(pc),
    .target(target), .stk_rdata(stk_rdata), .push(push), .pop(pop),
    .stk_wdata(stk_wdata), .next_pc(next_pc), .stall(stall),
    .depth(depth), .overflow(overflow), .underflow(underflow),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        push, pop, stall, fault, ovf, unf;
    logic [3:0]  depth;
    logic [11:0] npc, wd;
  } obs_t;

  typedef struct packed {
    logic        rs, c, r;
    logic [11:0] pc, tgt, rd;
    obs_t        e;
  } stim_t;

  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t mk(bit pu, bit po, bit st, bit fa, bit ov,
                              bit un, int d, int np, int wd);
    obs_t o;
    o.push = pu; o.pop = po; o.stall = st; o.fault = fa;
    o.ovf = ov; o.unf = un; o.depth = 4'(d);
    o.npc = 12'(np); o.wd = 12'(wd);
    return o;
  endfunction

  function automatic stim_t sv(bit rs, bit c, bit r, int p, int t,
                               int rd, obs_t e);
    stim_t s;
    s.rs = rs; s.c = c; s.r = r;
    s.pc = 12'(p); s.tgt = 12'(t); s.rd = 12'(rd); s.e = e;
    return s;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.push = push; o.pop = pop; o.stall = stall; o.fault = fault;
    o.ovf = overflow; o.unf = underflow; o.depth = depth;
    o.npc = next_pc; o.wd = stk_wdata;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rs; call = s.c; ret = s.r;
    pc = s.pc; target = s.tgt; stk_rdata = s.rd;
    sb.push_back(s.e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s[$];
    obs_t got, e;
    s.push_back(sv(0, 1, 0, 'h010, 'h100, 0,
                   mk(0,0,0,0,0,0, 0, 'h011, 'h011)));
    s.push_back(sv(1, 0, 0, 'h010, 'h100, 0,
                   mk(0,0,0,0,0,0, 0, 'h011, 'h011)));
    foreach (s[i]) begin
      drive(s[i]);
      got = cur(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call_ret();
    stim_t s[$];
    obs_t got, e;
    s.push_back(sv(1, 1, 0, 'h020, 'h100, 0,
                   mk(1,0,0,0,0,0, 0, 'h100, 'h021)));
    s.push_back(sv(1, 0, 1, 'h105, 0, 0,
                   mk(0,1,1,0,0,0, 1, 'h105, 'h106)));
    s.push_back(sv(1, 1, 1, 'h105, 'h333, 'h021,
                   mk(0,0,0,0,0,0, 0, 'h021, 'h106)));
    s.push_back(sv(1, 0, 0, 'h021, 0, 'h021,
                   mk(0,0,0,0,0,0, 0, 'h022, 'h022)));
    foreach (s[i]) begin
      drive(s[i]);
      got = cur(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL call_ret[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    stim_t s[$];
    obs_t got, e;
    for (int k = 0; k < 8; k++)
      s.push_back(sv(1, 1, 0, k, 'h200 + k, 0,
                     mk(1,0,0,0,0,0, k, 'h200 + k, k + 1)));
    s.push_back(sv(1, 1, 0, 'h050, 'h700, 0,
                   mk(0,0,1,0,0,0, 8, 'h050, 'h051)));
    s.push_back(sv(1, 1, 0, 'h051, 'h700, 0,
                   mk(0,0,1,1,1,0, 8, 'h051, 'h052)));
    s.push_back(sv(1, 0, 1, 'h052, 0, 'h123,
                   mk(0,0,1,1,1,0, 8, 'h052, 'h053)));
    s.push_back(sv(0, 1, 0, 'h053, 'h700, 0,
                   mk(0,0,0,0,0,0, 0, 'h054, 'h054)));
    s.push_back(sv(1, 0, 0, 'h054, 0, 0,
                   mk(0,0,0,0,0,0, 0, 'h055, 'h055)));
    foreach (s[i]) begin
      drive(s[i]);
      got = cur(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL overflow[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_underflow();
    stim_t s[$];
    obs_t got, e;
    s.push_back(sv(1, 0, 1, 'h030, 0, 'h0AA,
                   mk(0,0,1,0,0,0, 0, 'h030, 'h031)));
    s.push_back(sv(1, 0, 0, 'h031, 0, 'h0AA,
                   mk(0,0,1,1,0,1, 0, 'h031, 'h032)));
    s.push_back(sv(0, 0, 0, 'h031, 0, 0,
                   mk(0,0,0,0,0,0, 0, 'h032, 'h032)));
    foreach (s[i]) begin
      drive(s[i]);
      got = cur(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL underflow[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    obs_t got, e;
    s.push_back(sv(1, 1, 0, 'h040, 'h300, 0,
                   mk(1,0,0,0,0,0, 0, 'h300, 'h041)));
    s.push_back(sv(1, 1, 0, 'h300, 'h400, 0,
                   mk(1,0,0,0,0,0, 1, 'h400, 'h301)));
    s.push_back(sv(1, 1, 1, 'h400, 'h500, 0,
                   mk(1,0,0,0,0,0, 2, 'h500, 'h401)));
    s.push_back(sv(1, 1, 0, 'hFFF, 'h600, 0,
                   mk(1,0,0,0,0,0, 3, 'h600, 'h000)));
    s.push_back(sv(1, 0, 0, 'h600, 0, 0,
                   mk(0,0,0,0,0,0, 4, 'h601, 'h601)));
    foreach (s[i]) begin
      drive(s[i]);
      got = cur(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_ret();
    stim_t s[$];
    obs_t got, e;
    s.push_back(sv(0, 0, 0, 'h010, 0, 0,
                   mk(0,0,0,0,0,0, 0, 'h011, 'h011)));
    s.push_back(sv(1, 1, 0, 'h010, 'h080, 0,
                   mk(1,0,0,0,0,0, 0, 'h080, 'h011)));
    s.push_back(sv(1, 0, 1, 'h080, 0, 0,
                   mk(0,1,1,0,0,0, 1, 'h080, 'h081)));
    s.push_back(sv(0, 0, 0, 'h080, 0, 'h011,
                   mk(0,0,0,0,0,0, 0, 'h081, 'h081)));
    s.push_back(sv(1, 0, 0, 'h080, 0, 'h011,
                   mk(0,0,0,0,0,0, 0, 'h081, 'h081)));
    foreach (s[i]) begin
      drive(s[i]);
      got = cur(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_mid_ret[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; call = 1'b0; ret = 1'b0;
    pc = '0; target = '0; stk_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid_ret();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
